// File: rtl/matrix_pkg.sv
// Shared constants, read-sequencer state type and id check for the 3-matrix 8-bit store blocks.
package matrix_pkg;

  localparam int DATA_W  = 8;
  localparam int DIM     = 3;
  localparam int NUM_MAT = 3;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DIM - 1);
  localparam logic [IDX_W:0]   NUM_MAT_LIM = (IDX_W+1)'(NUM_MAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } rd_state_t;

  function automatic logic id_legal(input logic [IDX_W-1:0] id);
    return ({1'b0, id} < NUM_MAT_LIM);
  endfunction

endpackage

// File: rtl/matrix_reader_if.sv
// Store read-address bus plus element stream handshake between matrix_reader and its neighbours.
interface matrix_reader_if import matrix_pkg::*; ();

  logic [IDX_W-1:0]  mem_sel;
  logic [IDX_W-1:0]  mem_row;
  logic [IDX_W-1:0]  mem_col;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_col;
  logic              out_last;

  modport master (
    output mem_sel, mem_row, mem_col, out_valid, out_data, out_row, out_col, out_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_sel, mem_row, mem_col, out_valid, out_data, out_row, out_col, out_last,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/matrix_addr_counter.sv
// Row/col scan counter: synchronous clear, advance in row- or column-major order, last-position flag.
module matrix_addr_counter import matrix_pkg::*; (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  input  logic             col_major,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [IDX_W-1:0] row_r;
  logic [IDX_W-1:0] col_r;
  logic [IDX_W-1:0] row_nxt_s;
  logic [IDX_W-1:0] col_nxt_s;

  // Minor index steps first and wraps into the major index; callers never advance past the last slot.
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    if (clear) begin
      row_nxt_s = IDX_ZERO;
      col_nxt_s = IDX_ZERO;
    end else if (advance) begin
      if (col_major) begin
        if (row_r == IDX_LAST) begin
          row_nxt_s = IDX_ZERO;
          col_nxt_s = col_r + IDX_ONE;
        end else begin
          row_nxt_s = row_r + IDX_ONE;
          col_nxt_s = col_r;
        end
      end else begin
        if (col_r == IDX_LAST) begin
          col_nxt_s = IDX_ZERO;
          row_nxt_s = row_r + IDX_ONE;
        end else begin
          col_nxt_s = col_r + IDX_ONE;
          row_nxt_s = row_r;
        end
      end
    end else begin
      row_nxt_s = row_r;
      col_nxt_s = col_r;
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_r <= IDX_ZERO;
      col_r <= IDX_ZERO;
    end else begin
      row_r <= row_nxt_s;
      col_r <= col_nxt_s;
    end
  end

  assign row  = row_r;
  assign col  = col_r;
  assign last = (row_r == IDX_LAST) && (col_r == IDX_LAST);

endmodule

// File: rtl/matrix_reader.sv
// Read-side sequencer: scans one stored matrix and streams its elements with row/col/last tags.
// Optional build macro MATRIX_READER_TRANSPOSE_EN adds a `transpose` input for column-major scans.
module matrix_reader import matrix_pkg::*; (
  input  logic             clk,
  input  logic             reset_n,
`ifdef MATRIX_READER_TRANSPOSE_EN
  input  logic             transpose,
`endif
  input  logic             start,
  input  logic [IDX_W-1:0] matrix_id,
  output logic             busy,
  output logic             done,
  output logic             err,
  matrix_reader_if.master  bus
);

  rd_state_t         st_r;
  rd_state_t         st_nxt_s;
  logic              accept_s;
  logic              err_go_s;
  logic              cap_s;
  logic              fin_s;
  logic              err_fin_s;
  logic              adv_s;
  logic              clr_s;
  logic              col_major_s;
  logic [IDX_W-1:0]  cnt_row_s;
  logic [IDX_W-1:0]  cnt_col_s;
  logic              cnt_last_s;

  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [IDX_W-1:0]  sel_r;
  logic              valid_r;
  logic              last_r;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  row_r;
  logic [IDX_W-1:0]  col_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_r <= IDLE;
    end else begin
      st_r <= st_nxt_s;
    end
  end

  // Next state and one-cycle control strobes; the output register refills whenever it is empty or draining.
  always_comb begin
    st_nxt_s  = st_r;
    accept_s  = 1'b0;
    err_go_s  = 1'b0;
    cap_s     = 1'b0;
    fin_s     = 1'b0;
    err_fin_s = 1'b0;
    case (st_r)
      IDLE: begin
        if (start) begin
          if (id_legal(matrix_id)) begin
            accept_s = 1'b1;
            st_nxt_s = READ;
          end else begin
            err_go_s = 1'b1;
            st_nxt_s = ERR;
          end
        end else begin
          st_nxt_s = IDLE;
        end
      end
      READ: begin
        if (!valid_r || bus.out_ready) begin
          cap_s    = 1'b1;
          st_nxt_s = cnt_last_s ? DRAIN : READ;
        end else begin
          st_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          fin_s    = 1'b1;
          st_nxt_s = IDLE;
        end else begin
          st_nxt_s = DRAIN;
        end
      end
      ERR: begin
        err_fin_s = 1'b1;
        st_nxt_s  = IDLE;
      end
      default: begin
        st_nxt_s = IDLE;
      end
    endcase
  end

  assign adv_s = cap_s && !cnt_last_s;
  assign clr_s = accept_s || fin_s;

`ifdef MATRIX_READER_TRANSPOSE_EN
  logic tr_r;

  // Scan order is fixed for the whole scan once start is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tr_r <= 1'b0;
    end else if (accept_s) begin
      tr_r <= transpose;
    end else begin
      tr_r <= tr_r;
    end
  end

  assign col_major_s = tr_r;
`else
  assign col_major_s = 1'b0;
`endif

  matrix_addr_counter u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clr_s),
    .advance   (adv_s),
    .col_major (col_major_s),
    .row       (cnt_row_s),
    .col       (cnt_col_s),
    .last      (cnt_last_s)
  );

  // Status, select and output beat registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      sel_r   <= IDX_ZERO;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      row_r   <= IDX_ZERO;
      col_r   <= IDX_ZERO;
    end else begin
      done_r <= fin_s || err_fin_s;
      err_r  <= err_fin_s;

      if (accept_s || err_go_s) begin
        busy_r <= 1'b1;
      end else if (fin_s || err_fin_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end

      // An illegal id is never put on the store select lines.
      if (accept_s) begin
        sel_r <= matrix_id;
      end else if (fin_s) begin
        sel_r <= IDX_ZERO;
      end else begin
        sel_r <= sel_r;
      end

      if (cap_s) begin
        valid_r <= 1'b1;
        last_r  <= cnt_last_s;
        data_r  <= bus.mem_rdata;
        row_r   <= cnt_row_s;
        col_r   <= cnt_col_s;
      end else if (fin_s) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else begin
        valid_r <= valid_r;
        last_r  <= last_r;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign bus.mem_sel   = sel_r;
  assign bus.mem_row   = cnt_row_s;
  assign bus.mem_col   = cnt_col_s;
  assign bus.out_valid = valid_r;
  assign bus.out_last  = last_r;
  assign bus.out_data  = data_r;
  assign bus.out_row   = row_r;
  assign bus.out_col   = col_r;

endmodule

// File: tb/tb_matrix_reader.sv
// Randomized self-checking bench for matrix_reader against a queue-based scan model.
module tb_matrix_reader;
  import matrix_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] r;
    logic [1:0] c;
    logic       l;
  } beat_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] matrix_id;
  logic       busy;
  logic       done;
  logic       err;
`ifdef MATRIX_READER_TRANSPOSE_EN
  logic       transpose;
`endif

  logic [7:0] store [4][4][4];
  beat_t      exp_q [$];
  int         n_vec;
  int         n_err;

  matrix_reader_if mbus ();

  matrix_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef MATRIX_READER_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .start     (start),
    .matrix_id (matrix_id),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (mbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural store: combinational read.
  always_comb begin
    mbus.mem_rdata = store[mbus.mem_sel][mbus.mem_row][mbus.mem_col];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat list for a full scan: walk major index outer, minor index inner.
  task automatic build(input int id, input bit tr);
    exp_q.delete();
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        int r;
        int c;
        beat_t bt;
        r = tr ? b : a;
        c = tr ? a : b;
        bt.d = store[id][r][c];
        bt.r = r[1:0];
        bt.c = c[1:0];
        bt.l = (r == 2) && (c == 2);
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {27'd0, busy, done, err, mbus.out_valid, mbus.out_last}, 32'd0);
    check({tag, "_out"},  {20'd0, mbus.out_data, mbus.out_row, mbus.out_col}, 32'd0);
    check({tag, "_mem"},  {26'd0, mbus.mem_sel, mbus.mem_row, mbus.mem_col}, 32'd0);
  endtask

  // mode: 0 ready held high, 1 ready toggles, 2 random ready.
  task automatic run_scan(input logic [1:0] id, input bit tr, input int mode,
                          input int restart_at, input int abort_after);
    int    cyc;
    int    got;
    bit    fin;
    bit    rdy;
    bit    prev_stall;
    bit    abort_pend;
    beat_t prev;
    beat_t cur;
    beat_t e;
    build(int'(id), tr);
    @(negedge clk);
    start     = 1'b1;
    matrix_id = id;
`ifdef MATRIX_READER_TRANSPOSE_EN
    transpose = tr;
`endif
    @(negedge clk);
    start      = 1'b0;
    cyc        = 0;
    got        = 0;
    fin        = 1'b0;
    prev_stall = 1'b0;
    abort_pend = 1'b0;
    prev       = '0;
    while (!fin && cyc < 200) begin
      if (abort_pend) begin
        reset_n = 1'b0;
        #1;
        check_all_zero("abort_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_done", {31'd0, done}, 32'd0);
          check("abort_idle", {30'd0, busy, mbus.out_valid}, 32'd0);
        end
        return;
      end
      cur = {mbus.out_data, mbus.out_row, mbus.out_col, mbus.out_last};
      if (prev_stall) begin
        check("stall_valid", {31'd0, mbus.out_valid}, 32'd1);
        check("stall_hold", {19'd0, cur}, {19'd0, prev});
      end
      if (done) begin
        check("done_beats", got, 9);
        check("done_err", {30'd0, err, mbus.out_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_mem_idle", {26'd0, mbus.mem_sel, mbus.mem_row, mbus.mem_col}, 32'd0);
        if (mode == 0) check("start_to_done", cyc, 10);
        fin = 1'b1;
      end else begin
        check("busy_scan", {31'd0, busy}, 32'd1);
        check("mem_sel", {30'd0, mbus.mem_sel}, {30'd0, id});
        if (cyc == 0) check("valid_at_accept", {31'd0, mbus.out_valid}, 32'd0);
        if (mode == 0 && got == 0 && mbus.out_valid) check("first_valid_cyc", cyc, 1);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2) == 0;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        mbus.out_ready = rdy;
        if (cyc == restart_at) begin
          start     = 1'b1;
          matrix_id = 2'd2;
        end else begin
          start = 1'b0;
        end
        if (mbus.out_valid && rdy) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat", {19'd0, cur}, {19'd0, e});
          end
          got++;
          if (abort_after > 0 && got == abort_after) abort_pend = 1'b1;
        end
        prev_stall = mbus.out_valid && !rdy;
        prev       = cur;
        @(negedge clk);
        cyc++;
      end
    end
    start          = 1'b0;
    mbus.out_ready = 1'b1;
    if (!fin) check("done_timeout", 32'd0, 32'd1);
    check("beats_left", exp_q.size(), 0);
  endtask

  task automatic run_illegal();
    @(negedge clk);
    start     = 1'b1;
    matrix_id = 2'd3;
    @(negedge clk);
    start = 1'b0;
    check("ill_busy", {29'd0, busy, done, mbus.out_valid}, 32'b100);
    check("ill_mem", {30'd0, mbus.mem_sel}, 32'd0);
    @(negedge clk);
    check("ill_done", {28'd0, busy, done, err, mbus.out_valid}, 32'b0110);
    @(negedge clk);
    check("ill_after", {28'd0, busy, done, err, mbus.out_valid}, 32'b0000);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    reset_n        = 1'b0;
    start          = 1'b0;
    matrix_id      = 2'd0;
    mbus.out_ready = 1'b1;
`ifdef MATRIX_READER_TRANSPOSE_EN
    transpose      = 1'b0;
`endif
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          store[m][r][c] = 8'($urandom);
    for (int k = 0; k < 9; k++) store[1][k / 3][k % 3] = 8'h11 + 8'(k);

    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    run_scan(2'd1, 1'b0, 0, -1, 0);
    run_scan(2'd1, 1'b0, 1, -1, 0);
    run_illegal();
    run_scan(2'd0, 1'b0, 0, 3, 0);
    run_scan(2'd1, 1'b0, 0, -1, 4);
    run_scan(2'd2, 1'b0, 0, -1, 0);
`ifdef MATRIX_READER_TRANSPOSE_EN
    run_scan(2'd1, 1'b1, 0, -1, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      bit tr;
`ifdef MATRIX_READER_TRANSPOSE_EN
      tr = 1'($urandom_range(0, 1));
`else
      tr = 1'b0;
`endif
      run_scan(2'($urandom_range(0, 2)), tr, int'($urandom_range(0, 2)), -1, 0);
      if (i == 3) run_illegal();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
